vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Single-port VRAM arbiter directly upstream of the MC6845 display stage.
- Services the display fetch port (RD/DA in, DD out) with absolute priority.
- Interleaves CPU reads and writes into idle RAM slots, with a wait/ack handshake.
- Targets a synchronous 16KB x 8 VRAM with 1-cycle read latency.

Parameters:
AW, 14, address width (16KB VRAM)
DW, 8, data width
MAX_WAIT, 64, PEND cycles before cpu_starve is set (1..255)

Ports:
pixel_clock  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-high
vid_rd  in  1  display fetch strobe, one fetch per high cycle
vid_addr  in  AW  display fetch address
vid_data  out  DW  registered fetch data to display
cpu_req  in  1  CPU request level, already synchronous; 4-phase handshake
cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data; valid when cpu_ack=1, then held
cpu_ack  out  1  one-cycle completion pulse
cpu_wait  out  1  CPU wait-state request
cpu_starve  out  1  sticky flag: a CPU request waited >= MAX_WAIT cycles
ram_addr  out  AW  registered RAM address
ram_wdata  out  DW  registered RAM write data
ram_we  out  1  registered RAM write enable
ram_rdata  in  DW  RAM read data, valid one cycle after the address/edge

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: ram_we=0, ram_addr=0, ram_wdata=0, vid_data=0, cpu_rdata=0, cpu_ack=0, cpu_starve=0.
  - Internal: FSM=IDLE, wait counter=0.
  - Asserting reset mid-access drops ram_we immediately; a pending CPU access is discarded and never acked.
- Slots: each rising edge selects the next RAM cycle's ram_addr, ram_we and ram_wdata.
- Video slot (priority):
  - At an edge k where vid_rd=1: ram_addr<=vid_addr, ram_we<=0.
  - Edge k+1: ram_rdata is valid.
  - Edge k+2: vid_data<=ram_rdata. Fixed latency is 2 clocks.
  - vid_data holds between fetches.
  - Back-to-back vid_rd on every cycle is supported at full rate.
- CPU FSM states: IDLE, PEND, ISSUE, CAPT, ACK, HOLD.
  - IDLE: if cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, then go to PEND.
  - PEND:
    - If vid_rd=0 at this edge: ram_addr<=latched addr, ram_wdata<=latched data, ram_we<=latched we, then go to ISSUE.
    - Otherwise stay in PEND and increment the wait counter, saturating at 255.
    - When the counter reaches MAX_WAIT, set cpu_starve=1 (sticky until reset).
    - Video is never preempted.
  - ISSUE:
    - ram_we<=0, and this slot is free for video.
    - Go to CAPT on a read, or to ACK on a write.
  - CAPT: cpu_rdata<=ram_rdata, then go to ACK.
  - ACK: cpu_ack=1 for exactly this cycle, counter cleared; go to HOLD.
  - HOLD: wait for cpu_req=0, then go to IDLE. A held cpu_req never causes a second access.
- ram_we is high for exactly one cycle per CPU write, and never during a video slot.
- If vid_rd and a CPU issue want the same edge, video wins and the CPU stays in PEND.
- cpu_wait (combinational): cpu_req & (state not in {ACK, HOLD}).
  - It asserts in the same cycle cpu_req rises.
  - It drops in the ACK cycle.
- Timing with no video contention, counting from the edge that samples cpu_req in IDLE:
  - Write: ack after 3 edges.
  - Read: ack after 4 edges.
- Address collision (CPU write, then video read of the same address): the RAM serialises the two; a video read issued after the write slot returns the new data.

Test Plan:
- Idle video, CPU write 0x1234<=0xA5 -> one-cycle ram_we=1 with ram_addr=0x1234 and ram_wdata=0xA5; cpu_ack 3 edges after request; cpu_wait low during ACK.
- Idle video, CPU read 0x0010 with the RAM model holding 0x5A -> cpu_rdata=0x5A when cpu_ack=1, 4 edges after request; ram_we stays 0.
- vid_rd=1 for addresses 0..7 on consecutive cycles (RAM data = addr^0xFF) -> vid_data shows 0xFF, 0xFE, ..., 0xF8, each 2 clocks after its strobe.
- CPU write requested during a 10-cycle vid_rd burst -> PEND for the whole burst; write issued on the first cycle vid_rd=0; video data uncorrupted; cpu_starve stays 0.
- MAX_WAIT=4 with vid_rd held high for 6 cycles while CPU reads -> cpu_starve=1 and sticky; read still completes after vid_rd drops.
- Reset pulsed while in ISSUE of a write -> ram_we=0 at once, no cpu_ack ever; cpu_req held high after reset release -> new access starts from IDLE.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video fetch, CPU handshake and RAM port signals of the VRAM arbiter
interface vram_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          vid_rd;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_wait;
    logic          cpu_starve;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_data, cpu_rdata, cpu_ack, cpu_wait, cpu_starve, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_data, cpu_rdata, cpu_ack, cpu_wait, cpu_starve, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter, display fetch has priority, CPU fills idle slots
module vram_arbiter #(
    parameter int AW = 14,
    parameter int DW = 8,
    parameter int MAX_WAIT = 64
) (
    input logic          pixel_clock,
    input logic          reset,
    vram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PEND, ISSUE, CAPT, ACK, HOLD} state_t;

    state_t        state;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [7:0]    wait_cnt;
    logic [8:0]    wait_inc;
    logic [1:0]    vid_pipe;

    assign wait_inc = {1'b0, wait_cnt} + 9'd1;

    // CPU is held off from request until its completion pulse
    assign bus.cpu_wait = bus.cpu_req & ~(state == ACK || state == HOLD);

    // display fetch pipeline: strobe at k, RAM data valid at k+1, captured at k+2
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            vid_pipe     <= '0;
            bus.vid_data <= '0;
        end else begin
            vid_pipe <= {vid_pipe[0], bus.vid_rd};
            if (vid_pipe[1]) bus.vid_data <= bus.ram_rdata;
        end
    end

    // slot scheduler and CPU handshake FSM; a video strobe always owns the next RAM cycle
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lat_we         <= 1'b0;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            wait_cnt       <= '0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.ram_we     <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.cpu_ack    <= 1'b0;
            bus.cpu_starve <= 1'b0;
        end else begin
            bus.ram_we  <= 1'b0;
            bus.cpu_ack <= 1'b0;
            if (bus.vid_rd) bus.ram_addr <= bus.vid_addr;
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        lat_we    <= bus.cpu_we;
                        lat_addr  <= bus.cpu_addr;
                        lat_wdata <= bus.cpu_wdata;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (!bus.vid_rd) begin
                        bus.ram_addr  <= lat_addr;
                        bus.ram_wdata <= lat_wdata;
                        bus.ram_we    <= lat_we;
                        state         <= ISSUE;
                    end else begin
                        wait_cnt <= wait_inc[8] ? 8'hFF : wait_inc[7:0];
                        if (wait_inc >= 9'(MAX_WAIT)) bus.cpu_starve <= 1'b1;
                    end
                end
                ISSUE: begin
                    bus.cpu_ack <= lat_we;
                    state       <= lat_we ? ACK : CAPT;
                end
                CAPT: begin
                    bus.cpu_rdata <= bus.ram_rdata;
                    bus.cpu_ack   <= 1'b1;
                    state         <= ACK;
                end
                ACK: begin
                    wait_cnt <= '0;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (!bus.cpu_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of two arbiters (MAX_WAIT 64 and 4) against a transaction model
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vid_rd = 1'b0;
    logic [13:0] vid_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;

    logic [7:0]  mem_a [16384];
    logic [7:0]  mem_b [16384];
    logic [7:0]  ref_mem [16384];
    bit          vpat [128];
    logic [13:0] vadr [128];
    bit          sa, sb;
    logic [7:0]  vid_exp, rd_exp;
    int          checks = 0;
    int          failures = 0;

    vram_arbiter_if ia ();
    vram_arbiter_if ib ();

    vram_arbiter u_a (.pixel_clock(clk), .reset(reset), .bus(ia));
    vram_arbiter #(.MAX_WAIT(4)) u_b (.pixel_clock(clk), .reset(reset), .bus(ib));

    assign ia.vid_rd = vid_rd;     assign ib.vid_rd = vid_rd;
    assign ia.vid_addr = vid_addr; assign ib.vid_addr = vid_addr;
    assign ia.cpu_req = cpu_req;   assign ib.cpu_req = cpu_req;
    assign ia.cpu_we = cpu_we;     assign ib.cpu_we = cpu_we;
    assign ia.cpu_addr = cpu_addr; assign ib.cpu_addr = cpu_addr;
    assign ia.cpu_wdata = cpu_wdata; assign ib.cpu_wdata = cpu_wdata;

    always #5 clk = ~clk;

    // synchronous 1-cycle-latency VRAM models, one per arbiter
    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem_a[i] = 8'(i) ^ 8'hFF;
            mem_b[i] = 8'(i) ^ 8'hFF;
        end
        mem_a[16'h0010] = 8'h5A;
        mem_b[16'h0010] = 8'h5A;
        forever begin
            @(posedge clk);
            if (ia.ram_we) mem_a[ia.ram_addr] <= ia.ram_wdata;
            if (ib.ram_we) mem_b[ib.ram_addr] <= ib.ram_wdata;
            ia.ram_rdata <= mem_a[ia.ram_addr];
            ib.ram_rdata <= mem_b[ib.ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // one CPU access against the video strobe pattern in vpat/vadr; edge 0 samples cpu_req in IDLE
    task automatic run_txn(input bit we, input logic [13:0] addr, input logic [7:0] wd);
        int issue, ack_e, last, stop, st;
        issue = 1;
        while (vpat[issue]) issue++;
        ack_e = issue + (we ? 1 : 2);
        last = 0;
        for (int i = 0; i < 128; i++) if (vpat[i]) last = i;
        stop = ((ack_e > last + 2) ? ack_e : last + 2) + 2;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        vid_rd = vpat[0]; vid_addr = vadr[0];
        #1;
        chk("wait_rise", ia.cpu_wait, 1);
        for (int e = 0; e <= stop; e++) begin
            step;
            st = (e < issue - 1) ? e : issue - 1;
            if (st >= 64) sa = 1'b1;
            if (st >= 4) sb = 1'b1;
            if (!we && e == ack_e) rd_exp = ref_mem[addr];
            if (e >= 2 && vpat[e-2])
                vid_exp = (we && vadr[e-2] == addr && e - 2 > issue) ? wd : ref_mem[vadr[e-2]];
            chk("ack_a", ia.cpu_ack, e == ack_e);
            chk("ack_b", ib.cpu_ack, e == ack_e);
            chk("wait", ia.cpu_wait, e < ack_e);
            chk("ram_we_a", ia.ram_we, we && e == issue);
            chk("ram_we_b", ib.ram_we, we && e == issue);
            if (e == issue) begin
                chk("ram_addr_cpu", ia.ram_addr, addr);
                chk("ram_wdata", ia.ram_wdata, wd);
            end
            if (vpat[e]) chk("ram_addr_vid", ia.ram_addr, vadr[e]);
            chk("cpu_rdata", ia.cpu_rdata, rd_exp);
            chk("vid_data_a", ia.vid_data, vid_exp);
            chk("vid_data_b", ib.vid_data, vid_exp);
            chk("starve_a", ia.cpu_starve, sa);
            chk("starve_b", ib.cpu_starve, sb);
            vid_rd = vpat[e+1]; vid_addr = vadr[e+1];
        end
        if (we) ref_mem[addr] = wd;
        for (int i = 0; i < 128; i++) vpat[i] = 1'b0;
        cpu_req = 1'b0;
        step;
        step;
        chk("post_wait", ia.cpu_wait, 0);
        chk("post_ack", ia.cpu_ack, 0);
        chk("post_we", ia.ram_we, 0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'(i) ^ 8'hFF;
        ref_mem[16'h0010] = 8'h5A;
        for (int i = 0; i < 128; i++) begin vpat[i] = 1'b0; vadr[i] = '0; end
        sa = 1'b0; sb = 1'b0; vid_exp = '0; rd_exp = '0;

        step;
        step;
        chk("rst_ram_we", ia.ram_we, 0);
        chk("rst_ram_addr", ia.ram_addr, 0);
        chk("rst_ram_wdata", ia.ram_wdata, 0);
        chk("rst_vid_data", ia.vid_data, 0);
        chk("rst_cpu_rdata", ia.cpu_rdata, 0);
        chk("rst_cpu_ack", ia.cpu_ack, 0);
        chk("rst_starve", ia.cpu_starve, 0);
        chk("rst_wait", ia.cpu_wait, 0);
        reset = 1'b0;
        step;

        run_txn(1'b1, 14'h1234, 8'hA5);
        run_txn(1'b0, 14'h0010, 8'h00);

        for (int e = 0; e < 12; e++) begin
            vid_rd = (e < 8);
            vid_addr = e[13:0];
            step;
            if (e >= 2 && e < 10) vid_exp = ref_mem[e-2];
            if (e < 8) chk("burst_addr", ia.ram_addr, e);
            chk("burst_vid_a", ia.vid_data, vid_exp);
            chk("burst_vid_b", ib.vid_data, vid_exp);
        end
        vid_rd = 1'b0;

        for (int i = 0; i < 10; i++) begin vpat[i] = 1'b1; vadr[i] = 14'h0100 + 14'(i); end
        run_txn(1'b1, 14'h0200, 8'h77);
        for (int i = 0; i < 6; i++) begin vpat[i] = 1'b1; vadr[i] = 14'h0300 + 14'(i); end
        run_txn(1'b0, 14'h0010, 8'h00);
        run_txn(1'b0, 14'h0200, 8'h00);
        vpat[2] = 1'b1; vadr[2] = 14'h0040; vpat[4] = 1'b1; vadr[4] = 14'h0040;
        run_txn(1'b1, 14'h0040, 8'hC3);
        for (int i = 0; i < 64; i++) begin vpat[i] = 1'b1; vadr[i] = 14'(i); end
        run_txn(1'b1, 14'h0500, 8'h11);
        for (int i = 0; i < 65; i++) begin vpat[i] = 1'b1; vadr[i] = 14'(i); end
        run_txn(1'b0, 14'h0500, 8'h00);

        cpu_we = 1'b1; cpu_addr = 14'h0ABC; cpu_wdata = 8'h3C; cpu_req = 1'b1; vid_rd = 1'b0;
        step;
        step;
        chk("rst_mid_we_on", ia.ram_we, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_we_a", ia.ram_we, 0);
        chk("rst_mid_we_b", ib.ram_we, 0);
        step;
        chk("rst_mid_ack0", ia.cpu_ack, 0);
        step;
        chk("rst_mid_ack1", ia.cpu_ack, 0);
        chk("rst_mid_starve", ib.cpu_starve, 0);
        chk("rst_mid_nowrite", mem_a[16'h0ABC], ref_mem[16'h0ABC]);
        reset = 1'b0;
        sa = 1'b0; sb = 1'b0; vid_exp = '0; rd_exp = '0;
        run_txn(1'b1, 14'h0ABC, 8'h3C);

        for (int t = 0; t < 40; t++) begin
            int len;
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                vpat[i] = 1'($urandom_range(0, 1));
                vadr[i] = 14'($urandom_range(0, 15));
            end
            run_txn(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? 14'($urandom_range(0, 15)) : 14'($urandom),
                    8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
